scan_sel_ctrl: RTL and testbench

Sequential select generator that drives the 3-to-8 decoder stage (`in[2:0]`, `e`) directly upstream. It steps a 3-bit channel index through the enabled channels of an 8-bit mask. Each channel is held for a programmable dwell time, in single-pass or continuous mode. The downstream decoder turns `sel`/`e` into one-hot strobes for display digit or row scanning.

---
 rtl/scan_sel_ctrl_pkg.sv | 24 ++
 rtl/scan_sel_ctrl_next_chan_find.sv | 23 ++
 rtl/scan_sel_ctrl.sv | 161 ++++++++++++++++
 tb/tb_scan_sel_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/scan_sel_ctrl_pkg.sv
// Shared types and constants for the scan select generator.
// Build option SCAN_BLANK_EN (checked in scan_sel_ctrl) adds a blank cycle between channels.
package scan_pkg;

   localparam int NUM_CH = 8;
   localparam int SEL_W  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DWELL = 2'd1,
      BLANK = 2'd2
   } scan_state_e;

   // Index of the lowest set bit; zero when no bit is set.
   function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
      logic [SEL_W-1:0] r;
      r = {SEL_W{1'b0}};
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         r = m[i] ? SEL_W'(i) : r;
      end
      return r;
   endfunction

endpackage

// File: rtl/scan_sel_ctrl_next_chan_find.sv
// Combinational search for the next enabled channel above the current one,
// plus the lowest enabled channel used when a pass wraps.
module next_chan_find
   import scan_pkg::*;
(
   input  logic [NUM_CH-1:0] mask,
   input  logic [SEL_W-1:0]  cur,
   output logic [SEL_W-1:0]  nxt,
   output logic              found_above,
   output logic [SEL_W-1:0]  first
);

   logic [NUM_CH-1:0] above_s;

   // Clear bits 0..cur; the shift drops out of range when cur is the top channel.
   always_comb begin
      above_s     = mask & ~((NUM_CH'(2) << cur) - NUM_CH'(1));
      nxt         = lowest_set(above_s);
      found_above = |above_s;
      first       = lowest_set(mask);
   end

endmodule

// File: rtl/scan_sel_ctrl.sv
// Select generator for the 3-to-8 decoder: walks enabled channels with a dwell time.
// Define SCAN_BLANK_EN to insert one blank (e = 0) cycle on every channel transition.
module scan_sel_ctrl
   import scan_pkg::*;
#(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               mode,
   input  logic [NUM_CH-1:0]  mask,
   input  logic [DWELL_W-1:0] dwell,
   output logic [SEL_W-1:0]   sel,
   output logic               e,
   output logic               busy,
   output logic               done,
   output logic               wrap
);

   localparam logic [DWELL_W-1:0] CNT_ZERO = {DWELL_W{1'b0}};
   localparam logic [DWELL_W-1:0] CNT_ONE  = DWELL_W'(1);

   scan_state_e        state_r, state_s;
   logic [NUM_CH-1:0]  mask_r;
   logic               mode_r;
   logic [DWELL_W-1:0] reload_r, reload_s;
   logic [DWELL_W-1:0] cnt_r, cnt_s;
   logic [SEL_W-1:0]   sel_r, sel_s;
   logic               e_r, busy_r, done_r, wrap_r;
   logic               done_s, wrap_s;
   logic               accept_s, expire_s;
   logic [SEL_W-1:0]   nxt_s, first_s;
   logic               found_s;
   scan_state_e        step_st_s;

   next_chan_find u_find (
      .mask        (mask_r),
      .cur         (sel_r),
      .nxt         (nxt_s),
      .found_above (found_s),
      .first       (first_s)
   );

   assign accept_s = start & ~stop & (|mask);
   assign expire_s = (cnt_r == CNT_ZERO);

`ifdef SCAN_BLANK_EN
   assign step_st_s = BLANK;
`else
   assign step_st_s = DWELL;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; stop overrides any counter expiry.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_s = DWELL;
            else          state_s = IDLE;
         end
         DWELL: begin
            if (stop)                  state_s = IDLE;
            else if (!expire_s)        state_s = DWELL;
            else if (found_s || mode_r) state_s = step_st_s;
            else                       state_s = IDLE;
         end
         BLANK: begin
            if (stop) state_s = IDLE;
            else      state_s = DWELL;
         end
         default: state_s = IDLE;
      endcase
   end

   // Next values of the channel, counter and pulse outputs (registered below).
   always_comb begin
      sel_s    = sel_r;
      cnt_s    = cnt_r;
      reload_s = reload_r;
      done_s   = 1'b0;
      wrap_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               sel_s    = lowest_set(mask);
               reload_s = (dwell == CNT_ZERO) ? CNT_ZERO : (dwell - CNT_ONE);
               cnt_s    = reload_s;
            end else begin
               sel_s = sel_r;
            end
         end
         DWELL: begin
            if (stop) begin
               cnt_s = cnt_r;
            end else if (!expire_s) begin
               cnt_s = cnt_r - CNT_ONE;
            end else if (found_s) begin
               sel_s = nxt_s;
               cnt_s = reload_r;
            end else if (mode_r) begin
               sel_s  = first_s;
               cnt_s  = reload_r;
               wrap_s = 1'b1;
            end else begin
               done_s = 1'b1;
            end
         end
         BLANK: begin
            cnt_s = cnt_r;
         end
         default: begin
            cnt_s = cnt_r;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_r   <= {NUM_CH{1'b0}};
         mode_r   <= 1'b0;
         reload_r <= CNT_ZERO;
         cnt_r    <= CNT_ZERO;
         sel_r    <= {SEL_W{1'b0}};
         e_r      <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         wrap_r   <= 1'b0;
      end else begin
         if (state_r == IDLE && accept_s) begin
            mask_r <= mask;
            mode_r <= mode;
         end
         reload_r <= reload_s;
         cnt_r    <= cnt_s;
         sel_r    <= sel_s;
         e_r      <= (state_s == DWELL);
         busy_r   <= (state_s != IDLE);
         done_r   <= done_s;
         wrap_r   <= wrap_s;
      end
   end

   assign sel  = sel_r;
   assign e    = e_r;
   assign busy = busy_r;
   assign done = done_r;
   assign wrap = wrap_r;

endmodule

// File: tb/tb_scan_sel_ctrl.sv
// Directed self-checking bench for scan_sel_ctrl (blank test only with SCAN_BLANK_EN).
module tb_scan_sel_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, stop, mode;
   logic [7:0] mask, dwell;
   logic [2:0] sel;
   logic       e, busy, done, wrap;
   int         n_checks = 0;
   int         n_errors = 0;

   scan_sel_ctrl #(.DWELL_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
      .mask(mask), .dwell(dwell), .sel(sel), .e(e), .busy(busy),
      .done(done), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [7:0] m, input logic [7:0] d, input logic md);
      mask = m; dwell = d; mode = md; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   logic [2:0] exp_sel [8];

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; mask = 8'h00; dwell = 8'h00;
      tick(); tick();
      check("rst_sel", sel, 3'd0);
      check("rst_e", e, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_wrap", wrap, 1'b0);
      rst = 1'b0;
      tick();

      // Single pass over channels 0,2,5,7 with dwell 2; a start mid-pass is ignored.
      exp_sel = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd5, 3'd5, 3'd7, 3'd7};
      launch(8'b1010_0101, 8'd2, 1'b0);
      for (int i = 0; i < 8; i++) begin
         check("sp_sel", sel, exp_sel[i]);
         check("sp_e", e, 1'b1);
         check("sp_busy", busy, 1'b1);
         check("sp_done", done, 1'b0);
         if (i == 3) begin
            mask = 8'hFF; dwell = 8'd5; mode = 1'b1; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      start = 1'b0;
      check("sp_done_pulse", done, 1'b1);
      check("sp_e_end", e, 1'b0);
      check("sp_busy_end", busy, 1'b0);
      tick();
      check("sp_done_once", done, 1'b0);

      // Start with an empty mask is ignored.
      launch(8'h00, 8'd3, 1'b0);
      for (int i = 0; i < 2; i++) begin
         check("m0_busy", busy, 1'b0);
         check("m0_e", e, 1'b0);
         check("m0_done", done, 1'b0);
         check("m0_wrap", wrap, 1'b0);
         check("m0_sel", sel, 3'd7);
         tick();
      end

      // Continuous scan of channel 4 only, dwell 0 treated as 1.
      launch(8'h10, 8'd0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check("c1_sel", sel, 3'd4);
         check("c1_e", e, 1'b1);
         check("c1_wrap", wrap, (i == 0) ? 1'b0 : 1'b1);
         tick();
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("c1_stop_e", e, 1'b0);
      check("c1_stop_busy", busy, 1'b0);
      check("c1_stop_wrap", wrap, 1'b0);
      check("c1_stop_sel", sel, 3'd4);
      tick();

      // Stop on the expiry cycle of channel 3 wins over the advance.
      launch(8'h18, 8'd2, 1'b0);
      check("sp3_sel0", sel, 3'd3);
      tick();
      check("sp3_sel1", sel, 3'd3);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("sp3_e", e, 1'b0);
      check("sp3_busy", busy, 1'b0);
      check("sp3_done", done, 1'b0);
      check("sp3_sel", sel, 3'd3);
      tick();
      check("sp3_done2", done, 1'b0);
      check("sp3_sel2", sel, 3'd3);

`ifdef SCAN_BLANK_EN
      // Two channels, continuous, with blanking between them.
      launch(8'h03, 8'd1, 1'b1);
      check("bl_e0", e, 1'b1); check("bl_sel0", sel, 3'd0); check("bl_w0", wrap, 1'b0);
      tick();
      check("bl_e1", e, 1'b0); check("bl_sel1", sel, 3'd1); check("bl_w1", wrap, 1'b0);
      tick();
      check("bl_e2", e, 1'b1); check("bl_sel2", sel, 3'd1); check("bl_w2", wrap, 1'b0);
      tick();
      check("bl_e3", e, 1'b0); check("bl_sel3", sel, 3'd0); check("bl_w3", wrap, 1'b1);
      tick();
      check("bl_e4", e, 1'b1); check("bl_sel4", sel, 3'd0); check("bl_w4", wrap, 1'b0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();
`endif

      // Reset asynchronously while channel 4 is being driven.
      launch(8'hFF, 8'd3, 1'b0);
`ifdef SCAN_BLANK_EN
      for (int i = 0; i < 16; i++) tick();
`else
      for (int i = 0; i < 13; i++) tick();
`endif
      check("rm_sel_before", sel, 3'd4);
      check("rm_e_before", e, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("rm_e", e, 1'b0);
      check("rm_busy", busy, 1'b0);
      check("rm_sel", sel, 3'd0);
      check("rm_done", done, 1'b0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rm_done_after", done, 1'b0);
         check("rm_busy_after", busy, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
